// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle spawn scheduler.
// The LFSR tap mask is only consumed when RANDOM_LANE_EN is defined.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SEARCH = 2'd2,
    ISSUE  = 2'd3
  } spawn_state_t;

  localparam int LEVEL_W     = 2;
  localparam int OBJ_COUNT_W = 11;
  localparam int LANE_W      = 2;

  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/free_slot_finder.sv
// Rotate-priority encoder: first clear bit of busy at or above start, wrapping.
module free_slot_finder
  import game_pkg::*;
#(
  parameter int NSLOTS = 4
) (
  input  logic [NSLOTS-1:0]         busy,
  input  logic [$clog2(NSLOTS)-1:0] start,
  output logic                      found,
  output logic [$clog2(NSLOTS)-1:0] index
);

  localparam int IDX_W = $clog2(NSLOTS);

  logic [IDX_W-1:0] cand;

  // Walk from the far end down so the slot closest to start wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (!busy[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Paces obstacle spawns per level, claims free slots round-robin, issues valid/ready requests.
// Define RANDOM_LANE_EN to pick lanes from an 8-bit LFSR instead of a rotating counter.
module obstacle_spawn_scheduler
  import game_pkg::*;
#(
  parameter int         NSLOTS      = 4,
  parameter int         INTERVAL_L0 = 60,
  parameter int         INTERVAL_L1 = 40,
  parameter int         INTERVAL_L2 = 25,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hit,
  input  logic                      frame_tick,
  input  logic [LEVEL_W-1:0]        level,
  input  logic [NSLOTS-1:0]         slot_busy,
  input  logic                      spawn_ready,
  output logic                      spawn_valid,
  output logic [$clog2(NSLOTS)-1:0] spawn_slot,
  output logic [LANE_W-1:0]         spawn_lane,
  output logic [LEVEL_W-1:0]        spawn_shape,
  output logic [OBJ_COUNT_W-1:0]    obj_count,
  output logic                      stalled
);

  localparam int IDX_W = $clog2(NSLOTS);

  if (NSLOTS < 2 || NSLOTS > 16 || (NSLOTS & (NSLOTS - 1)) != 0 ||
      INTERVAL_L0 < 1 || INTERVAL_L0 > 255 || INTERVAL_L1 < 1 || INTERVAL_L1 > 255 ||
      INTERVAL_L2 < 1 || INTERVAL_L2 > 255 || LFSR_SEED == 8'h00) begin : g_param_check
    $error("obstacle_spawn_scheduler: illegal parameter set");
  end

  function automatic logic [7:0] interval_last(input logic [LEVEL_W-1:0] lv);
    case (lv)
      2'd0:    return 8'(INTERVAL_L0 - 1);
      2'd1:    return 8'(INTERVAL_L1 - 1);
      default: return 8'(INTERVAL_L2 - 1);
    endcase
  endfunction

  function automatic logic [OBJ_COUNT_W-1:0] sat_inc(input logic [OBJ_COUNT_W-1:0] v);
    return (v == '1) ? v : v + OBJ_COUNT_W'(1);
  endfunction

  spawn_state_t            state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        slot_q, slot_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [LEVEL_W-1:0]      shape_q, shape_d;
  logic [OBJ_COUNT_W-1:0]  obj_q, obj_d;
  logic                    accept;
  logic                    found;
  logic [IDX_W-1:0]        free_idx;
  logic [LANE_W-1:0]       new_lane;

  free_slot_finder #(.NSLOTS(NSLOTS)) u_finder (
    .busy  (slot_busy),
    .start (rr_q),
    .found (found),
    .index (free_idx)
  );

`ifdef RANDOM_LANE_EN
  logic [7:0]        lfsr_q;
  logic [LANE_W-1:0] lane_pick;

  // Free-running; hit leaves it alone so lane sequences keep diverging between lives.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_comb begin
    lane_pick = lfsr_q[1:0];
    if (lane_pick == lane_q) lane_pick = lane_pick + 2'd1;
  end

  assign new_lane = lane_pick;
`else
  logic [LANE_W-1:0] lane_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)       lane_cnt_q <= '0;
    else if (accept) lane_cnt_q <= lane_cnt_q + 2'd1;
  end

  assign new_lane = lane_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    slot_d  = slot_q;
    lane_d  = lane_q;
    shape_d = shape_q;
    obj_d   = obj_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (frame_tick) state_d = COUNT;
      COUNT: begin
        if (frame_tick) begin
          if (cnt_q >= interval_last(level)) begin
            cnt_d   = '0;
            state_d = SEARCH;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      SEARCH: begin
        if (found) begin
          slot_d  = free_idx;
          lane_d  = new_lane;
          shape_d = level;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (spawn_ready) begin
          obj_d   = sat_inc(obj_q);
          rr_d    = slot_q + IDX_W'(1);
          accept  = 1'b1;
          state_d = COUNT;
        end
      end
      default: state_d = IDLE;
    endcase
    // A collision aborts any pending request and restarts pacing from IDLE.
    if (hit) begin
      state_d = IDLE;
      cnt_d   = '0;
      obj_d   = '0;
      rr_d    = rr_q;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      slot_q  <= '0;
      lane_q  <= '0;
      shape_q <= '0;
      obj_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      slot_q  <= slot_d;
      lane_q  <= lane_d;
      shape_q <= shape_d;
      obj_q   <= obj_d;
    end
  end

  assign spawn_valid = (state_q == ISSUE);
  assign stalled     = (state_q == SEARCH) && !found;
  assign spawn_slot  = slot_q;
  assign spawn_lane  = lane_q;
  assign spawn_shape = shape_q;
  assign obj_count   = obj_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: scenario tasks against a transaction-level spawn model.
module tb_obstacle_spawn_scheduler;

  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, hit = 1'b0, frame_tick = 1'b0, spawn_ready = 1'b0;
  logic [1:0] level = 2'd0;
  logic [3:0] slot_busy = 4'h0;
  logic       spawn_valid, stalled;
  logic [1:0] spawn_slot, spawn_lane, spawn_shape;
  logic [10:0] obj_count;

  logic       f_reset = 1'b1, f_hit = 1'b0, f_tick = 1'b0, f_ready = 1'b0;
  logic [1:0] f_level = 2'd0;
  logic [3:0] f_busy = 4'h0;
  logic       f_valid, f_stalled;
  logic [1:0] f_slot, f_lane, f_shape;
  logic [10:0] f_obj;

  obstacle_spawn_scheduler dut (
    .clk(clk), .reset(reset), .hit(hit), .frame_tick(frame_tick), .level(level),
    .slot_busy(slot_busy), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_slot(spawn_slot), .spawn_lane(spawn_lane), .spawn_shape(spawn_shape),
    .obj_count(obj_count), .stalled(stalled)
  );

  obstacle_spawn_scheduler #(.INTERVAL_L0(1)) dut_fast (
    .clk(clk), .reset(f_reset), .hit(f_hit), .frame_tick(f_tick), .level(f_level),
    .slot_busy(f_busy), .spawn_ready(f_ready), .spawn_valid(f_valid),
    .spawn_slot(f_slot), .spawn_lane(f_lane), .spawn_shape(f_shape),
    .obj_count(f_obj), .stalled(f_stalled)
  );

  int tests = 0;
  int fails = 0;

  // Transaction-level model: where the next spawn goes and what it carries.
  int         m_rr = 0;
  int         m_lane = 0;
  int         m_obj = 0;
  logic [1:0] m_prev_lane = 2'd0;

  function automatic int ivl(input logic [1:0] l);
    return (l == 2'd0) ? 60 : (l == 2'd1) ? 40 : 25;
  endfunction

  function automatic int first_free(input int from, input logic [3:0] b);
    for (int i = 0; i < NS; i++) begin
      int s;
      s = (from + i) % NS;
      if (!b[s]) return s;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rr = 0; m_lane = 0; m_obj = 0; m_prev_lane = 2'd0;
  endtask

  task automatic tick_n(input int n, input int per);
    bit early;
    early = 1'b0;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (spawn_valid !== 1'b0) early = 1'b1;
      for (int p = 1; p < per; p++) begin
        step();
        if (spawn_valid !== 1'b0) early = 1'b1;
      end
    end
    if (n > 0) begin
      tests++;
      if (early) begin
        fails++;
        $display("FAIL early_valid: spawn_valid seen during %0d non-expiring ticks, required 0", n);
      end
    end
  endtask

  task automatic run_spawn(input int ticks, input int per, input int rdy_delay, input string tag);
    logic [1:0] es, esh, el;
    bit unstable;
    es  = 2'(first_free(m_rr, slot_busy));
    esh = level;
    el  = 2'(m_lane);
    if (ticks > 1) tick_n(ticks - 1, per);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    tests++;
    if (spawn_valid !== 1'b0 || stalled !== 1'b0) begin
      fails++;
      $display("FAIL %s_search: valid=%b stalled=%b, required 0/0", tag, spawn_valid, stalled);
    end
    step();
    tests++;
    if (spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_latency: valid=%b two cycles after expiring tick, required 1", tag, spawn_valid);
    end
    tests++;
    if (spawn_slot !== es || spawn_shape !== esh) begin
      fails++;
      $display("FAIL %s_payload: slot=%0d shape=%0d, required slot=%0d shape=%0d",
               tag, spawn_slot, spawn_shape, es, esh);
    end
    tests++;
`ifdef RANDOM_LANE_EN
    if (spawn_lane === m_prev_lane) begin
      fails++;
      $display("FAIL %s_lane: lane=%0d repeats previous lane %0d", tag, spawn_lane, m_prev_lane);
    end
`else
    if (spawn_lane !== el) begin
      fails++;
      $display("FAIL %s_lane: lane=%0d, required %0d", tag, spawn_lane, el);
    end
`endif
    m_prev_lane = spawn_lane;
    unstable = 1'b0;
    for (int d = 0; d < rdy_delay; d++) begin
      step();
      if (spawn_valid !== 1'b1 || spawn_slot !== es || spawn_lane !== m_prev_lane ||
          spawn_shape !== esh || obj_count !== 11'(m_obj)) unstable = 1'b1;
    end
    if (rdy_delay > 0) begin
      tests++;
      if (unstable) begin
        fails++;
        $display("FAIL %s_hold: request changed while ready=0 (obj_count=%0d, required %0d)",
                 tag, obj_count, m_obj);
      end
    end
    spawn_ready = 1'b1; step(); spawn_ready = 1'b0;
    m_obj  = (m_obj < 2047) ? m_obj + 1 : m_obj;
    m_rr   = (int'(es) + 1) % NS;
    m_lane = (m_lane + 1) % 4;
    tests++;
    if (spawn_valid !== 1'b0 || obj_count !== 11'(m_obj)) begin
      fails++;
      $display("FAIL %s_accept: valid=%b obj_count=%0d, required 0/%0d", tag, spawn_valid, obj_count, m_obj);
    end
  endtask

  task automatic reach_issue(input int ticks, input string tag);
    tick_n(ticks - 1, 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    tests++;
    if (spawn_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_reach_issue: valid=%b, required 1", tag, spawn_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step();
    tests++;
    if (spawn_valid !== 1'b0 || stalled !== 1'b0 || obj_count !== 11'd0) begin
      fails++;
      $display("FAIL reset_ctrl: valid=%b stalled=%b obj=%0d, required 0/0/0", spawn_valid, stalled, obj_count);
    end
    tests++;
    if (spawn_slot !== 2'd0 || spawn_lane !== 2'd0 || spawn_shape !== 2'd0) begin
      fails++;
      $display("FAIL reset_payload: slot=%0d lane=%0d shape=%0d, required 0/0/0", spawn_slot, spawn_lane, spawn_shape);
    end
    reset = 1'b0;
    model_reset();
    repeat (5) step();
    tests++;
    if (spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_quiet: valid=%b without ticks, required 0", spawn_valid);
    end
  endtask

  task automatic test_basic_spawn();
    level = 2'd0; slot_busy = 4'h0;
    run_spawn(61, 4, 0, "basic1");
    run_spawn(60, 4, 0, "basic2");
  endtask

  task automatic test_level_change();
    level = 2'd0; slot_busy = 4'h0;
    tick_n(30, 4);
    level = 2'd2;
    run_spawn(1, 4, 0, "lvl_switch");
    run_spawn(25, 4, 0, "lvl2_next");
  endtask

  task automatic test_stall();
    int k;
    level = 2'd2; slot_busy = 4'hF;
    tick_n(24, 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    tests++;
    if (stalled !== 1'b1 || spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_enter: stalled=%b valid=%b, required 1/0", stalled, spawn_valid);
    end
    repeat (5) step();
    tests++;
    if (stalled !== 1'b1 || spawn_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: stalled=%b valid=%b, required 1/0", stalled, spawn_valid);
    end
    slot_busy = 4'b1011;
    k = 0;
    while (k < 2 && spawn_valid !== 1'b1) begin
      step();
      k++;
    end
    tests++;
    if (spawn_valid !== 1'b1 || spawn_slot !== 2'd2 || stalled !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: valid=%b slot=%0d stalled=%b, required 1/2/0", spawn_valid, spawn_slot, stalled);
    end
    m_prev_lane = spawn_lane;
    spawn_ready = 1'b1; step(); spawn_ready = 1'b0;
    m_obj  = (m_obj < 2047) ? m_obj + 1 : m_obj;
    m_rr   = 3;
    m_lane = (m_lane + 1) % 4;
    tests++;
    if (obj_count !== 11'(m_obj)) begin
      fails++;
      $display("FAIL stall_accept: obj_count=%0d, required %0d", obj_count, m_obj);
    end
    slot_busy = 4'h0;
  endtask

  task automatic test_backpressure();
    level = 2'd1; slot_busy = 4'h0;
    run_spawn(40, 2, 10, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] b;
      level = 2'($urandom_range(0, 3));
      b = 4'($urandom);
      if (b == 4'hF) b[$urandom_range(0, 3)] = 1'b0;
      slot_busy = b;
      run_spawn(ivl(level), int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), "random");
    end
    slot_busy = 4'h0;
  endtask

  task automatic test_hit();
    level = 2'd2; slot_busy = 4'b1001;
    run_spawn(25, 1, 0, "pre_hit");
    reach_issue(25, "hit");
    hit = 1'b1; step(); hit = 1'b0;
    m_obj = 0;
    tests++;
    if (spawn_valid !== 1'b0 || obj_count !== 11'd0 || stalled !== 1'b0) begin
      fails++;
      $display("FAIL hit_clear: valid=%b obj=%0d stalled=%b, required 0/0/0", spawn_valid, obj_count, stalled);
    end
    run_spawn(26, 1, 0, "after_hit");
    reach_issue(25, "rst_hit");
    reset = 1'b1; hit = 1'b1; step(); reset = 1'b0; hit = 1'b0;
    model_reset();
    tests++;
    if (spawn_valid !== 1'b0 || obj_count !== 11'd0 || spawn_slot !== 2'd0 ||
        spawn_lane !== 2'd0 || spawn_shape !== 2'd0 || stalled !== 1'b0) begin
      fails++;
      $display("FAIL rst_hit_values: valid=%b obj=%0d slot=%0d lane=%0d shape=%0d, required all 0",
               spawn_valid, obj_count, spawn_slot, spawn_lane, spawn_shape);
    end
    level = 2'd0; slot_busy = 4'h0;
    run_spawn(61, 1, 0, "after_reset");
  endtask

  task automatic test_saturation();
    int acc, cyc;
    bit bad_seq, bad_cnt;
    logic [1:0] prev;
    acc = 0; cyc = 0; bad_seq = 1'b0; bad_cnt = 1'b0; prev = 2'd0;
    f_reset = 1'b1; f_ready = 1'b1; f_level = 2'd0; f_busy = 4'h0; f_tick = 1'b0;
    step(); step();
    f_reset = 1'b0; f_tick = 1'b1;
    while (acc < 2100 && cyc < 20000) begin
      if (f_valid === 1'b1) begin
        if (f_slot !== 2'(acc % NS)) bad_seq = 1'b1;
`ifdef RANDOM_LANE_EN
        if (f_lane === prev) bad_seq = 1'b1;
`else
        if (f_lane !== 2'(acc % 4)) bad_seq = 1'b1;
`endif
        prev = f_lane;
        acc++;
      end
      step();
      cyc++;
      if (f_obj !== 11'((acc < 2047) ? acc : 2047)) bad_cnt = 1'b1;
    end
    tests++;
    if (acc < 2100) begin
      fails++;
      $display("FAIL sat_timeout: %0d spawns accepted in %0d cycles, required 2100", acc, cyc);
    end
    tests++;
    if (f_obj !== 11'd2047) begin
      fails++;
      $display("FAIL sat_hold: obj_count=%0d, required 2047", f_obj);
    end
    tests++;
    if (bad_cnt) begin
      fails++;
      $display("FAIL sat_track: obj_count diverged from accepted count (now %0d, accepted %0d)", f_obj, acc);
    end
    tests++;
    if (bad_seq) begin
      fails++;
      $display("FAIL sat_sequence: slot/lane sequence broke rotation (last slot=%0d lane=%0d)", f_slot, f_lane);
    end
    f_tick = 1'b0; f_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_spawn();
    test_level_change();
    test_stall();
    test_backpressure();
    test_random();
    test_hit();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
